// File: rtl/level_debounce.sv
// Two-flop (or deeper) synchroniser followed by a four-state debouncer.
// Output edges commit only after D+1 consecutive mismatching synchronised samples.
module level_debounce #(
    parameter int unsigned SYNC_STAGES  = 2,
    parameter int unsigned CNT_WIDTH    = 16,
    parameter int unsigned GLITCH_WIDTH = 8
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    level_in,
    input  logic                    enable,
    input  logic [CNT_WIDTH-1:0]    debounce_cycles,
    input  logic                    glitch_clear,
    output logic                    level_out,
    output logic                    busy,
    output logic [GLITCH_WIDTH-1:0] glitch_count
);

    // Encoding chosen so level_out and busy are direct flop bits.
    typedef enum logic [1:0] {
        StLo    = 2'b00,
        StChkHi = 2'b01,
        StHi    = 2'b10,
        StChkLo = 2'b11
    } state_e;

    state_e                  state_q, state_d;
    logic [CNT_WIDTH-1:0]    cnt_q, cnt_d;
    logic [GLITCH_WIDTH-1:0] glitch_q, glitch_d;
    logic [SYNC_STAGES-1:0]  sync_q;
    logic                    level_sync;
    logic                    glitch_event;

    assign level_sync   = sync_q[SYNC_STAGES-1];
    assign level_out    = state_q[1];
    assign busy         = state_q[0];
    assign glitch_count = glitch_q;

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        glitch_event = 1'b0;
        if (enable) begin
            unique case (state_q)
                StLo, StHi: begin
                    if (level_sync != level_out) begin
                        if (debounce_cycles == '0) begin
                            state_d = (state_q == StLo) ? StHi : StLo;
                            cnt_d   = '0;
                        end else begin
                            state_d = (state_q == StLo) ? StChkHi : StChkLo;
                            cnt_d   = CNT_WIDTH'(1);
                        end
                    end
                end
                StChkHi, StChkLo: begin
                    if (level_sync == level_out) begin
                        state_d      = (state_q == StChkHi) ? StLo : StHi;
                        cnt_d        = '0;
                        glitch_event = 1'b1;
                    end else if (cnt_q >= debounce_cycles) begin
                        state_d = (state_q == StChkHi) ? StHi : StLo;
                        cnt_d   = '0;
                    end else if (cnt_q != '1) begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            endcase
        end
    end

    always_comb begin
        glitch_d = glitch_q;
        if (glitch_clear) begin
            glitch_d = '0;
        end else if (glitch_event && (glitch_q != '1)) begin
            glitch_d = glitch_q + 1'b1;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            sync_q   <= '0;
            state_q  <= StLo;
            cnt_q    <= '0;
            glitch_q <= '0;
        end else begin
            sync_q   <= {sync_q[SYNC_STAGES-2:0], level_in};
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            glitch_q <= glitch_d;
        end
    end

endmodule

// File: tb/tb_level_debounce.sv
// Bench for level_debounce: directed vector table, corner-case sequences and a random run
// against a sample-counting reference model. A second instance checks 2-bit saturation.
module tb_level_debounce;

    localparam int unsigned SYNC = 2;
    localparam int unsigned CW   = 16;

    logic          clock = 1'b0;
    logic          reset;
    logic          level_in;
    logic          enable;
    logic [CW-1:0] debounce_cycles;
    logic          glitch_clear;
    logic          level_out, busy, level_out2, busy2;
    logic [7:0]    glitch_count;
    logic [1:0]    glitch_count2;

    int checks = 0;
    int errors = 0;

    // Reference model state
    bit m_hist[$];
    bit m_out;
    int m_run;
    int m_gtot;

    always #5 clock = ~clock;

    level_debounce #(.SYNC_STAGES(SYNC), .CNT_WIDTH(CW), .GLITCH_WIDTH(8)) dut (
        .clock           (clock),
        .reset           (reset),
        .level_in        (level_in),
        .enable          (enable),
        .debounce_cycles (debounce_cycles),
        .glitch_clear    (glitch_clear),
        .level_out       (level_out),
        .busy            (busy),
        .glitch_count    (glitch_count)
    );

    level_debounce #(.SYNC_STAGES(SYNC), .CNT_WIDTH(CW), .GLITCH_WIDTH(2)) dut2 (
        .clock           (clock),
        .reset           (reset),
        .level_in        (level_in),
        .enable          (enable),
        .debounce_cycles (debounce_cycles),
        .glitch_clear    (glitch_clear),
        .level_out       (level_out2),
        .busy            (busy2),
        .glitch_count    (glitch_count2)
    );

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
        end
    endtask

    function automatic int sat(input int v, input int lim);
        return (v > lim) ? lim : v;
    endfunction

    task automatic model_reset();
        m_hist.delete();
        for (int i = 0; i < SYNC; i++) m_hist.push_back(1'b0);
        m_out  = 1'b0;
        m_run  = 0;
        m_gtot = 0;
    endtask

    // One clock: model consumes the inputs present at the edge, then outputs are compared.
    task automatic tick();
        bit s;
        bit gev;
        @(posedge clock);
        gev = 1'b0;
        if (reset) begin
            model_reset();
        end else begin
            s = m_hist.pop_front();
            m_hist.push_back(level_in);
            if (enable) begin
                if (s != m_out) begin
                    m_run++;
                    if (m_run >= int'(debounce_cycles) + 1) begin
                        m_out = ~m_out;
                        m_run = 0;
                    end
                end else if (m_run > 0) begin
                    m_run = 0;
                    gev   = 1'b1;
                end
            end
            if (glitch_clear) m_gtot = 0;
            else if (gev) m_gtot++;
        end
        #1;
        chk("model_level_out", int'(level_out), int'(m_out));
        chk("model_busy", int'(busy), (m_run > 0) ? 1 : 0);
        chk("model_glitch8", int'(glitch_count), sat(m_gtot, 255));
        chk("model_glitch2", int'(glitch_count2), sat(m_gtot, 3));
        chk("inst2_level_out", int'(level_out2), int'(m_out));
    endtask

    task automatic do_reset();
        reset        = 1'b1;
        level_in     = 1'b0;
        glitch_clear = 1'b0;
        enable       = 1'b1;
        tick();
        tick();
        reset = 1'b0;
    endtask

    typedef struct {
        bit rst;
        bit lin;
        bit clr;
        bit eo;
        bit eb;
        int eg;
    } vec_t;

    function automatic vec_t mk(bit rst, bit lin, bit clr, bit eo, bit eb, int eg);
        vec_t v;
        v.rst = rst; v.lin = lin; v.clr = clr; v.eo = eo; v.eb = eb; v.eg = eg;
        return v;
    endfunction

    task automatic glitch_pulse(input bit clr_on_event);
        level_in = 1'b1; tick(); tick();
        level_in = 1'b0; tick(); tick();
        glitch_clear = clr_on_event;
        tick();
        glitch_clear = 1'b0;
        tick();
    endtask

    initial begin
        vec_t tbl[$];
        int   hold;

        reset           = 1'b1;
        level_in        = 1'b0;
        enable          = 1'b1;
        glitch_clear    = 1'b0;
        debounce_cycles = CW'(3);
        model_reset();

        // Clean rise, clean fall, 2-cycle glitch, clear (D=3)
        tbl.push_back(mk(1, 0, 0, 0, 0, 0));
        for (int i = 1; i <= 7; i++)
            tbl.push_back(mk(0, 1, 0, i >= 6, (i >= 3) && (i <= 5), 0));
        for (int i = 8; i <= 14; i++)
            tbl.push_back(mk(0, 0, 0, i <= 12, (i >= 10) && (i <= 12), 0));
        tbl.push_back(mk(0, 1, 0, 0, 0, 0));
        tbl.push_back(mk(0, 1, 0, 0, 0, 0));
        tbl.push_back(mk(0, 0, 0, 0, 1, 0));
        tbl.push_back(mk(0, 0, 0, 0, 1, 0));
        tbl.push_back(mk(0, 0, 0, 0, 0, 1));
        tbl.push_back(mk(0, 0, 0, 0, 0, 1));
        tbl.push_back(mk(0, 0, 1, 0, 0, 0));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0));

        foreach (tbl[i]) begin
            reset        = tbl[i].rst;
            level_in     = tbl[i].lin;
            glitch_clear = tbl[i].clr;
            tick();
            chk($sformatf("vec%0d_level_out", i), int'(level_out), int'(tbl[i].eo));
            chk($sformatf("vec%0d_busy", i), int'(busy), int'(tbl[i].eb));
            chk($sformatf("vec%0d_glitch", i), int'(glitch_count), tbl[i].eg);
        end
        glitch_clear = 1'b0;

        // Bypass: D=0, fixed 3-edge latency, busy never set
        debounce_cycles = '0;
        do_reset();
        for (int i = 0; i < 24; i++) begin
            level_in = ((i / 4) % 2) == 1;
            tick();
            chk("bypass_busy", int'(busy), 0);
            if (i >= 2) chk("bypass_follow", int'(level_out), ((i - 2) / 4) % 2);
        end
        chk("bypass_glitch", int'(glitch_count), 0);

        // Freeze at cnt=2 with D=5
        debounce_cycles = CW'(5);
        do_reset();
        level_in = 1'b1;
        for (int i = 0; i < 4; i++) tick();
        enable = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick();
            chk("freeze_level_out", int'(level_out), 0);
            chk("freeze_busy", int'(busy), 1);
        end
        enable = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            tick();
            chk("resume_level_out", int'(level_out), (i == 4) ? 1 : 0);
        end

        // Reset mid-check
        debounce_cycles = CW'(3);
        do_reset();
        level_in = 1'b1;
        for (int i = 0; i < 3; i++) tick();
        chk("midchk_busy", int'(busy), 1);
        reset = 1'b1;
        tick();
        chk("midrst_level_out", int'(level_out), 0);
        chk("midrst_busy", int'(busy), 0);
        chk("midrst_glitch", int'(glitch_count), 0);
        reset = 1'b0;
        for (int i = 1; i <= 6; i++) begin
            tick();
            chk("postrst_level_out", int'(level_out), (i == 6) ? 1 : 0);
        end

        // Saturation on the 2-bit instance, then clear coincident with a glitch
        do_reset();
        for (int i = 0; i < 5; i++) glitch_pulse(1'b0);
        chk("sat_glitch2", int'(glitch_count2), 3);
        chk("sat_glitch8", int'(glitch_count), 5);
        glitch_pulse(1'b1);
        chk("clr_win_glitch2", int'(glitch_count2), 0);
        chk("clr_win_glitch8", int'(glitch_count), 0);

        // Random run against the model
        do_reset();
        hold = 0;
        for (int i = 0; i < 3000; i++) begin
            if (hold == 0) begin
                level_in = 1'($urandom_range(0, 1));
                hold     = $urandom_range(1, 8);
            end
            hold--;
            if ($urandom_range(0, 99) < 5) debounce_cycles = CW'($urandom_range(0, 6));
            enable       = ($urandom_range(0, 99) < 90);
            glitch_clear = ($urandom_range(0, 99) < 3);
            reset        = ($urandom_range(0, 999) < 5);
            tick();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/level_debounce.md
Name: level_debounce

Overview:
- Synchroniser plus debouncer for slow external or cross-domain level inputs (buttons, handshake request lines, status pins).
- Output is a clean, glitch-free level on the local clock. It drives the edge-to-pulse converter directly downstream.
- A transition on the output is committed only after the synchronised input has held its new value for a programmable number of cycles.
- Rejected glitches are counted for diagnostics.

Parameters:
- SYNC_STAGES, 2, number of synchroniser flops on level_in (legal >= 2).
- CNT_WIDTH, 16, width of debounce_cycles and of the internal stability counter.
- GLITCH_WIDTH, 8, width of the saturating glitch counter.

Ports:
- clock  input  1  sole clock; all state updates on its rising edge.
- reset  input  1  synchronous, active-high reset.
- level_in  input  1  raw, possibly asynchronous level.
- enable  input  1  1 = debouncer runs; 0 = freeze.
- debounce_cycles  input  CNT_WIDTH  qualification length D; sampled live every cycle.
- glitch_clear  input  1  synchronous clear of glitch_count.
- level_out  output  1  debounced level.
- busy  output  1  1 while a candidate transition is being qualified.
- glitch_count  output  GLITCH_WIDTH  number of rejected transitions, saturating.

Behaviour:
- Clock and reset: one clock; reset is synchronous and active-high.
- Reset values: all synchroniser flops 0, level_out 0, busy 0, stability counter 0, glitch_count 0, FSM in ST_LO. Reset applied mid-qualification discards the candidate and does not count a glitch.
- Synchroniser: level_in shifts through SYNC_STAGES flops; level_sync is the last stage. The synchroniser shifts regardless of enable.
- FSM states:
  - ST_LO: level_out=0, busy=0.
  - ST_CHK_HI: level_out=0, busy=1.
  - ST_HI: level_out=1, busy=0.
  - ST_CHK_LO: level_out=1, busy=1.
  - level_out and busy are registered state decodes.
- Stable state (ST_LO / ST_HI): if level_sync differs from level_out, go to the matching CHK state with cnt <= 1. Exception: if D == 0, commit immediately, i.e. go directly to the opposite stable state.
- CHK state, level_sync back to the old value: return to the stable state, cnt <= 0, glitch_count += 1 (saturating at all-ones).
- CHK state, level_sync still new and cnt >= D: commit to the opposite stable state, cnt <= 0.
- CHK state, otherwise: cnt <= cnt + 1.
- Qualification length: a change requires D+1 consecutive mismatching level_sync samples. level_out toggles on edge SYNC_STAGES + D + 1, counted from the first edge that samples the new level_in.
- Live D changes: the compare is >=, so a D reduced below cnt mid-check commits on the next mismatching cycle. cnt must never wrap; it saturates at all-ones.
- enable = 0:
  - FSM and cnt hold their current values; level_out and busy stay constant; no glitch is counted.
  - On re-enable, qualification resumes from the held cnt.
- glitch_clear: glitch_count <= 0. If a glitch event occurs in the same cycle, clear wins.
- Saturation: glitch_count holds at 2^GLITCH_WIDTH - 1.

Test Plan:
- Clean rise: SYNC_STAGES=2, D=3; level_in 0->1 sampled at edge 1 and held -> busy=1 after edge 3; level_out=1 after edge 6; busy=0 after edge 6.
- Glitch: D=3; level_in high for exactly 2 cycles -> level_out stays 0; busy pulses; glitch_count=1. Then glitch_clear=1 for one cycle -> glitch_count=0.
- Bypass: D=0; level_in toggles every 4 cycles -> level_out follows with a fixed 3-edge latency; busy never asserts; glitch_count=0.
- Freeze: D=5; deassert enable at cnt=2 for 10 cycles with level_in held high -> level_out=0 throughout. After re-enable, level_out=1 after 4 further edges.
- Reset mid-check: D=3; assert reset while in ST_CHK_HI -> next cycle all outputs 0, glitch_count=0. With level_in still high, level_out=1 six edges after reset release.
- Saturation: GLITCH_WIDTH=2; inject 5 glitches -> glitch_count=3. Then glitch_clear coincident with a 6th glitch -> glitch_count=0.
